// File: rtl/beta_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : beta_pkg                                                   |
// | Brief   : Shared Beta ISA constants, NOP encoding, pc_sel encoding.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package beta_pkg;

    localparam logic [5:0]  C_OP_LD     = 6'h18;
    localparam logic [5:0]  C_OP_ST     = 6'h19;
    localparam logic [5:0]  C_OP_JMP    = 6'h1B;
    localparam logic [5:0]  C_OP_BEQ    = 6'h1C;
    localparam logic [5:0]  C_OP_BNE    = 6'h1D;
    localparam logic [5:0]  C_OP_LDR    = 6'h1F;

    localparam logic [4:0]  C_R31       = 5'd31;

    // ADDC R31,0,R31: writes nothing architecturally visible.
    localparam logic [31:0] C_NOP_INSTR = 32'hC3FF_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JMP    = 2'd2
    } pc_sel_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regfile                                                    |
// | Brief   : 32x32 register file, 2 combinational reads, 1 sync write, |
// |           R31 hardwired to zero, no write-through.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module regfile
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [4:0]  i_ra1,
    output logic [31:0] o_rd1,
    input  logic [4:0]  i_ra2,
    output logic [31:0] o_rd2
);

    logic [31:0] r_mem [0:31];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we && (i_wa != C_R31)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == C_R31) ? 32'd0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == C_R31) ? 32'd0 : r_mem[i_ra2];

endmodule
`default_nettype wire

// File: rtl/rf_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_stage                                                   |
// | Brief   : Beta register-fetch stage: decode, register read, load-use |
// |           interlock, branch/JMP resolution and RF/EX pipeline reg.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_stage
    import beta_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_if,
    input  logic [31:0] pc_if,
    input  logic [31:0] a_op,
    input  logic [31:0] b_op,
    input  logic        wb_we,
    input  logic [4:0]  wb_rc,
    input  logic [31:0] wb_data,
    input  logic        ex_is_ld,
    input  logic [4:0]  ex_rc,
    output logic [4:0]  ra_sel,
    output logic [4:0]  rb_sel,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic        stall,
    output logic [1:0]  pc_sel,
    output logic [31:0] br_target,
    output logic [31:0] ex_instr,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_d
);

    logic [31:0] r_instr_rf;
    logic [31:0] r_pc_rf;
    logic [31:0] r_ex_instr;
    logic [31:0] r_ex_pc;
    logic [31:0] r_ex_a;
    logic [31:0] r_ex_b;
    logic [31:0] r_ex_d;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rc;
    logic [4:0]  w_ra;
    logic [4:0]  w_rb;
    logic [15:0] w_literal;
    logic [31:0] w_lit_sext;
    logic [4:0]  w_rb_sel;
    logic        w_is_st;
    logic        w_ra_used;
    logic        w_rb_used;
    logic        w_ld_hazard;
    logic        w_stall;
    logic        w_a_zero;
    logic        w_use_lit;
    logic        w_taken;
    logic [31:0] w_br_target;
    pc_sel_e     w_pc_sel;

    assign w_opcode   = r_instr_rf[31:26];
    assign w_rc       = r_instr_rf[25:21];
    assign w_ra       = r_instr_rf[20:16];
    assign w_rb       = r_instr_rf[15:11];
    assign w_literal  = r_instr_rf[15:0];
    assign w_lit_sext = sext16(w_literal);

    assign w_is_st    = (w_opcode == C_OP_ST);
    // ST reads its store-data register through the Rc field.
    assign w_rb_sel   = w_is_st ? w_rc : w_rb;

    assign w_ra_used  = (w_opcode != C_OP_LDR);
    assign w_rb_used  = (w_opcode[5:4] == 2'b10) || w_is_st;

    assign w_ld_hazard = ex_is_ld && (ex_rc != C_R31) &&
                         ((w_ra_used && (ex_rc == w_ra)) ||
                          (w_rb_used && (ex_rc == w_rb_sel)));
    assign w_stall     = !rst && w_ld_hazard;

    assign w_a_zero    = (a_op == 32'd0);

    // A stall masks any branch decision; the branch re-evaluates once the load clears.
    always_comb begin
        w_pc_sel = PC_SEQ;
        if (!rst && !w_stall) begin
            if (((w_opcode == C_OP_BEQ) && w_a_zero) ||
                ((w_opcode == C_OP_BNE) && !w_a_zero)) begin
                w_pc_sel = PC_BRANCH;
            end else if (w_opcode == C_OP_JMP) begin
                w_pc_sel = PC_JMP;
            end
        end
    end

    assign w_taken     = (w_pc_sel != PC_SEQ);
    assign w_br_target = (w_opcode == C_OP_JMP) ? {a_op[31:2], 2'b00}
                                                : r_pc_rf + {w_lit_sext[29:0], 2'b00};

    assign w_use_lit   = (w_opcode[5:4] == 2'b11) ||
                         (w_opcode == C_OP_LD) || (w_opcode == C_OP_ST);

    regfile u_regfile (
        .clk   (clk),
        .i_we  (wb_we),
        .i_wa  (wb_rc),
        .i_wd  (wb_data),
        .i_ra1 (w_ra),
        .o_rd1 (rd1),
        .i_ra2 (w_rb_sel),
        .o_rd2 (rd2)
    );

    // IF/RF register: held on stall, annulled after a taken branch or JMP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_rf <= C_NOP_INSTR;
            r_pc_rf    <= 32'd0;
        end else if (!w_stall) begin
            r_instr_rf <= w_taken ? C_NOP_INSTR : instr_if;
            r_pc_rf    <= pc_if;
        end
    end

    // RF/EX register: a stall injects a bubble carrying pc_rf.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_instr <= C_NOP_INSTR;
            r_ex_pc    <= 32'd0;
            r_ex_a     <= 32'd0;
            r_ex_b     <= 32'd0;
            r_ex_d     <= 32'd0;
        end else if (w_stall) begin
            r_ex_instr <= C_NOP_INSTR;
            r_ex_pc    <= r_pc_rf;
        end else begin
            r_ex_instr <= r_instr_rf;
            r_ex_pc    <= r_pc_rf;
            r_ex_a     <= a_op;
            r_ex_b     <= w_use_lit ? w_lit_sext : b_op;
            r_ex_d     <= b_op;
        end
    end

    assign ra_sel    = w_ra;
    assign rb_sel    = w_rb_sel;
    assign stall     = w_stall;
    assign pc_sel    = w_pc_sel;
    assign br_target = w_br_target;
    assign ex_instr  = r_ex_instr;
    assign ex_pc     = r_ex_pc;
    assign ex_a      = r_ex_a;
    assign ex_b      = r_ex_b;
    assign ex_d      = r_ex_d;

endmodule
`default_nettype wire

// File: tb/tb_rf_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rf_stage                                                |
// | Brief   : Self-checking bench for rf_stage with a behavioural model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rf_stage;

    localparam logic [31:0] NOP = 32'hC3FF_0000;
    localparam logic [5:0]  LD = 6'h18, ST = 6'h19, JMP = 6'h1B,
                            BEQ = 6'h1C, BNE = 6'h1D, LDR = 6'h1F, ADD = 6'h20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_if, pc_if, a_op, b_op, wb_data;
    logic        wb_we, ex_is_ld;
    logic [4:0]  wb_rc, ex_rc;
    logic [4:0]  ra_sel, rb_sel;
    logic [31:0] rd1, rd2, br_target, ex_instr, ex_pc, ex_a, ex_b, ex_d;
    logic        stall;
    logic [1:0]  pc_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_stage dut (
        .clk(clk), .rst(rst), .instr_if(instr_if), .pc_if(pc_if),
        .a_op(a_op), .b_op(b_op), .wb_we(wb_we), .wb_rc(wb_rc),
        .wb_data(wb_data), .ex_is_ld(ex_is_ld), .ex_rc(ex_rc),
        .ra_sel(ra_sel), .rb_sel(rb_sel), .rd1(rd1), .rd2(rd2),
        .stall(stall), .pc_sel(pc_sel), .br_target(br_target),
        .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b), .ex_d(ex_d)
    );

    // Behavioural model state.
    logic [31:0] m_regs [32];
    logic [31:0] m_ir, m_pc, m_ex_instr, m_ex_pc, m_ex_a, m_ex_b, m_ex_d;

    function automatic logic [31:0] mk(input logic [5:0] op, input int rc, input int ra, input int rb);
        return {op, 5'(rc), 5'(ra), 5'(rb), 11'd0};
    endfunction

    function automatic logic [31:0] mk_lit(input logic [5:0] op, input int rc, input int ra, input logic [15:0] lit);
        return {op, 5'(rc), 5'(ra), lit};
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [5:0] m_op();
        return m_ir[31:26];
    endfunction

    function automatic int m_ra();
        return int'(m_ir[20:16]);
    endfunction

    function automatic int m_rb();
        return (m_op() == ST) ? int'(m_ir[25:21]) : int'(m_ir[15:11]);
    endfunction

    function automatic logic [31:0] m_read(input int r);
        return (r == 31) ? 32'd0 : m_regs[r];
    endfunction

    function automatic logic m_stall();
        logic uses_a, uses_b;
        uses_a = (m_op() != LDR);
        uses_b = (m_op() >= 6'h20 && m_op() < 6'h30) || (m_op() == ST);
        if (rst || !ex_is_ld || ex_rc == 5'd31) return 1'b0;
        return (uses_a && int'(ex_rc) == m_ra()) || (uses_b && int'(ex_rc) == m_rb());
    endfunction

    function automatic logic [1:0] m_pc_sel();
        if (rst || m_stall()) return 2'd0;
        if (m_op() == BEQ && a_op == 0) return 2'd1;
        if (m_op() == BNE && a_op != 0) return 2'd1;
        if (m_op() == JMP) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] m_target();
        if (m_op() == JMP) return (a_op >> 2) << 2;
        return m_pc + sx(m_ir[15:0]) * 32'd4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [1:0] ps;
        ps = m_pc_sel();
        chk("ra_sel", 32'(ra_sel), 32'(m_ra()));
        chk("rb_sel", 32'(rb_sel), 32'(m_rb()));
        chk("rd1", rd1, m_read(m_ra()));
        chk("rd2", rd2, m_read(m_rb()));
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("pc_sel", 32'(pc_sel), 32'(ps));
        if (ps != 2'd0) chk("br_target", br_target, m_target());
        chk("ex_instr", ex_instr, m_ex_instr);
        chk("ex_pc", ex_pc, m_ex_pc);
        chk("ex_a", ex_a, m_ex_a);
        chk("ex_b", ex_b, m_ex_b);
        chk("ex_d", ex_d, m_ex_d);
    endtask

    task automatic model_reset();
        m_ir = NOP; m_pc = 0;
        m_ex_instr = NOP; m_ex_pc = 0; m_ex_a = 0; m_ex_b = 0; m_ex_d = 0;
    endtask

    task automatic model_update();
        logic st, taken, lit;
        st    = m_stall();
        taken = (m_pc_sel() != 2'd0);
        lit   = (m_op() >= 6'h30) || (m_op() == LD) || (m_op() == ST);
        if (rst) begin
            model_reset();
        end else if (st) begin
            m_ex_instr = NOP;
            m_ex_pc    = m_pc;
        end else begin
            m_ex_instr = m_ir;
            m_ex_pc    = m_pc;
            m_ex_a     = a_op;
            m_ex_b     = lit ? sx(m_ir[15:0]) : b_op;
            m_ex_d     = b_op;
            m_ir       = taken ? NOP : instr_if;
            m_pc       = pc_if;
        end
        if (wb_we && wb_rc != 5'd31) m_regs[wb_rc] = wb_data;
    endtask

    // Inputs are applied 1ns after a rising edge; compare then advance one cycle.
    task automatic tick();
        #2;
        compare_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] add_i, beq_i;

    initial begin
        rst = 1; instr_if = NOP; pc_if = 0; a_op = 0; b_op = 0;
        wb_we = 0; wb_rc = 0; wb_data = 0; ex_is_ld = 0; ex_rc = 0;
        @(posedge clk); #1;
        model_reset();

        for (int i = 0; i < 32; i++) begin
            wb_we = 1; wb_rc = 5'(i); wb_data = $urandom;
            tick();
        end
        rst = 0;

        // Register write then read, and R31 reads zero.
        instr_if = mk(ADD, 1, 5, 31); wb_we = 1; wb_rc = 5; wb_data = 32'h1234;
        tick();
        wb_we = 0; instr_if = mk(ADD, 1, 31, 31);
        #1 chk("r5_read", rd1, 32'h1234);
        tick();
        #1 chk("r31_read", rd1, 32'd0);

        // Load-use interlock.
        add_i = mk(ADD, 6, 3, 4);
        instr_if = add_i;
        tick();
        ex_is_ld = 1; ex_rc = 3; instr_if = NOP;
        #1 chk("ld_use_stall", 32'(stall), 32'd1);
        tick();
        #1 chk("bubble_instr", ex_instr, NOP);
        ex_is_ld = 0;
        #1 chk("stall_clears", 32'(stall), 32'd0);
        tick();
        #1 chk("add_held", ex_instr, add_i);

        // BEQ taken with negative offset, fetched instruction annulled.
        beq_i = mk_lit(BEQ, 31, 2, 16'hFFFE);
        instr_if = beq_i; pc_if = 32'h100;
        tick();
        a_op = 0; instr_if = add_i; pc_if = 32'h104;
        #1 chk("beq_pc_sel", 32'(pc_sel), 32'd1);
        chk("beq_target", br_target, 32'hF8);
        tick();
        instr_if = NOP;
        #1 chk("beq_ex_instr", ex_instr, beq_i);
        chk("beq_ex_pc", ex_pc, 32'h100);
        chk("annul_ra", 32'(ra_sel), 32'd31);
        tick();
        #1 chk("annul_nop", ex_instr, NOP);

        // JMP target alignment.
        instr_if = mk(JMP, 31, 4, 0);
        tick();
        a_op = 32'h203; instr_if = NOP;
        #1 chk("jmp_pc_sel", 32'(pc_sel), 32'd2);
        chk("jmp_target", br_target, 32'h200);
        tick();

        // ST uses Rc as rb_sel and literal as ex_b.
        instr_if = mk_lit(ST, 7, 2, 16'd8);
        tick();
        instr_if = NOP; a_op = 32'h40; b_op = 32'hDEADBEEF;
        #1 chk("st_rb_sel", 32'(rb_sel), 32'd7);
        tick();
        #1 chk("st_ex_b", ex_b, 32'd8);
        chk("st_ex_d", ex_d, 32'hDEADBEEF);

        // Reset during a stall.
        instr_if = add_i;
        tick();
        instr_if = NOP; ex_is_ld = 1; ex_rc = 4;
        #1 chk("pre_rst_stall", 32'(stall), 32'd1);
        rst = 1;
        #1 chk("rst_stall_low", 32'(stall), 32'd0);
        tick();
        chk("rst_ex_instr", ex_instr, NOP);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_b", ex_b, 32'd0);
        chk("rst_ex_d", ex_d, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 0; ex_is_ld = 0;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            int rc, ra, rb;
            case ($urandom_range(0, 9))
                0: op = LD;   1: op = ST;  2: op = JMP; 3: op = BEQ;
                4: op = BNE;  5: op = LDR; 6: op = ADD; 7: op = 6'h30;
                8: op = 6'h28;
                default: op = 6'($urandom);
            endcase
            rc = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
            rb = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 7));
            instr_if = {op, 5'(rc), 5'(ra), 5'(rb), 11'($urandom)};
            pc_if    = $urandom;
            a_op     = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            b_op     = $urandom;
            wb_we    = 1'($urandom);
            wb_rc    = 5'($urandom);
            wb_data  = $urandom;
            ex_is_ld = ($urandom_range(0, 2) == 0);
            ex_rc    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            rst      = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
